fp_subtractor_seq: RTL and testbench

- Iterative, multi-cycle IEEE754 single-precision subtractor. Computes O = A - B.
- The inverse-direction companion to the combinational fp_adder. It trades latency for area: alignment and normalization shift one bit per cycle.
- Sits in the accelerator datapath, e.g. error/gradient terms, behind a valid/ready handshake on both sides.
- Uses the same arithmetic conventions as fp_adder: truncation (no rounding), and denormals treated as exponent 1 with hidden bit 0.

---
 rtl/fp_subtractor_seq.sv | 181 ++++++++++++++++++
 tb/tb_fp_subtractor_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_subtractor_seq.sv
// Iterative IEEE754 single-precision subtractor, O = A - B.
// Alignment and normalization move one bit per clock to keep the datapath small.
// Arithmetic truncates (no rounding); denormals use exponent 1 with hidden bit 0.
module fp_subtractor_seq #(
    parameter int MAX_ALIGN = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] O,
    output logic        busy
);

    localparam int CW = $clog2(MAX_ALIGN + 1);
    localparam logic [7:0]    MAX_ALIGN8  = 8'(MAX_ALIGN);
    localparam logic [CW-1:0] MAX_ALIGN_C = CW'(MAX_ALIGN);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] UNPACK = 3'd1;
    localparam logic [2:0] ALIGN  = 3'd2;
    localparam logic [2:0] SUB    = 3'd3;
    localparam logic [2:0] NORM   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]    state;
    logic [31:0]   a_r, b_r, o_r;
    logic          sign_l, sign_s;
    logic [7:0]    exp_r;
    logic [23:0]   man_l, man_s;
    logic [CW-1:0] cnt;
    logic [24:0]   res;

    // Operand decode used by UNPACK; B's sign is flipped so the op becomes A + (-B)
    logic          a_sign, b_sign;
    logic [7:0]    a_exp, b_exp;
    logic [22:0]   a_frac, b_frac;
    logic          a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [23:0]   a_man, b_man;
    logic          a_is_l;
    logic [7:0]    exp_diff;
    logic [CW-1:0] align_amt;
    logic          special;
    logic [31:0]   special_o;

    assign a_sign = a_r[31];
    assign b_sign = ~b_r[31];
    assign a_frac = a_r[22:0];
    assign b_frac = b_r[22:0];
    assign a_nan  = (a_r[30:23] == 8'hFF) && (a_frac != 23'd0);
    assign b_nan  = (b_r[30:23] == 8'hFF) && (b_frac != 23'd0);
    assign a_inf  = (a_r[30:23] == 8'hFF) && (a_frac == 23'd0);
    assign b_inf  = (b_r[30:23] == 8'hFF) && (b_frac == 23'd0);
    assign a_zero = (a_r[30:0] == 31'd0);
    assign b_zero = (b_r[30:0] == 31'd0);

    // Denormals get exponent 1 and no hidden bit
    assign a_exp  = (a_r[30:23] == 8'd0) ? 8'd1 : a_r[30:23];
    assign b_exp  = (b_r[30:23] == 8'd0) ? 8'd1 : b_r[30:23];
    assign a_man  = {(a_r[30:23] != 8'd0), a_frac};
    assign b_man  = {(b_r[30:23] != 8'd0), b_frac};

    // Pick the larger operand (ties favour A) and clamp the alignment distance
    assign a_is_l    = (a_exp > b_exp) || ((a_exp == b_exp) && (a_man >= b_man));
    assign exp_diff  = a_is_l ? (a_exp - b_exp) : (b_exp - a_exp);
    assign align_amt = (exp_diff >= MAX_ALIGN8) ? MAX_ALIGN_C : exp_diff[CW-1:0];

    // Special-case resolution in priority order: NaNs, infinities, then zeros
    always_comb begin
        special   = 1'b1;
        special_o = 32'h0;
        if (a_nan) begin
            special_o = a_r;
        end else if (b_nan) begin
            special_o = b_r;
        end else if (a_inf && b_inf) begin
            special_o = (a_sign == b_sign) ? {a_sign, 8'hFF, 23'd0} : 32'h7FC00000;
        end else if (a_inf) begin
            special_o = {a_sign, 8'hFF, 23'd0};
        end else if (b_inf) begin
            special_o = {b_sign, 8'hFF, 23'd0};
        end else if (b_zero) begin
            special_o = a_r;
        end else if (a_zero) begin
            special_o = {b_sign, b_r[30:0]};
        end else begin
            special = 1'b0;
        end
    end

    // Main sequencer: capture, unpack, align, add/subtract, normalize, hold result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_r    <= 32'h0;
            b_r    <= 32'h0;
            o_r    <= 32'h0;
            sign_l <= 1'b0;
            sign_s <= 1'b0;
            exp_r  <= 8'd0;
            man_l  <= 24'd0;
            man_s  <= 24'd0;
            cnt    <= '0;
            res    <= 25'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= A;
                        b_r   <= B;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (special) begin
                        o_r   <= special_o;
                        state <= DONE;
                    end else begin
                        sign_l <= a_is_l ? a_sign : b_sign;
                        sign_s <= a_is_l ? b_sign : a_sign;
                        exp_r  <= a_is_l ? a_exp : b_exp;
                        man_l  <= a_is_l ? a_man : b_man;
                        man_s  <= a_is_l ? b_man : a_man;
                        cnt    <= align_amt;
                        state  <= (align_amt != '0) ? ALIGN : SUB;
                    end
                end
                ALIGN: begin
                    man_s <= man_s >> 1;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= SUB;
                    end
                end
                SUB: begin
                    if (sign_l == sign_s) begin
                        res <= {1'b0, man_l} + {1'b0, man_s};
                    end else begin
                        res <= {1'b0, man_l} - {1'b0, man_s};
                    end
                    state <= NORM;
                end
                NORM: begin
                    if (res == 25'd0) begin
                        o_r   <= 32'h0;
                        state <= DONE;
                    end else if (res[24]) begin
                        res   <= res >> 1;
                        exp_r <= exp_r + 8'd1;
                        if (exp_r + 8'd1 == 8'hFF) begin
                            o_r   <= {sign_l, 8'hFF, 23'd0};
                            state <= DONE;
                        end
                    end else if (!res[23] && (exp_r > 8'd1)) begin
                        res   <= res << 1;
                        exp_r <= exp_r - 8'd1;
                    end else begin
                        o_r   <= {sign_l, (res[23] ? exp_r : 8'd0), res[22:0]};
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign O         = o_r;

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Self-checking bench for fp_subtractor_seq: directed cases, handshake,
// asynchronous reset and randomized operands against a reference model.
module tb_fp_subtractor_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] O;
    logic        busy;

    int tests_run;
    int tests_failed;

    fp_subtractor_seq #(.MAX_ALIGN(25)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .O         (O),
        .busy      (busy)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: value-level rules for A - B with truncation; returns result and latency
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] o, output int lat);
        logic sa, sb, sl, ss;
        int ea, eb, fa, fb, ma, mb, xa, xb, ml, ms, d, r, e, n;
        logic [31:0] rv;
        sa = a[31];
        sb = ~b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = int'(a[22:0]);
        fb = int'(b[22:0]);
        lat = 1;
        if (ea == 255 && fa != 0) begin
            o = a;
        end else if (eb == 255 && fb != 0) begin
            o = b;
        end else if (ea == 255 && eb == 255) begin
            o = (sa == sb) ? {sa, 8'hFF, 23'd0} : 32'h7FC00000;
        end else if (ea == 255) begin
            o = {sa, 8'hFF, 23'd0};
        end else if (eb == 255) begin
            o = {sb, 8'hFF, 23'd0};
        end else if (eb == 0 && fb == 0) begin
            o = a;
        end else if (ea == 0 && fa == 0) begin
            o = {sb, b[30:0]};
        end else begin
            ma = (ea == 0) ? fa : (fa + (1 << 23));
            mb = (eb == 0) ? fb : (fb + (1 << 23));
            xa = (ea == 0) ? 1 : ea;
            xb = (eb == 0) ? 1 : eb;
            if (xa > xb || (xa == xb && ma >= mb)) begin
                ml = ma; ms = mb; e = xa; sl = sa; ss = sb; d = xa - xb;
            end else begin
                ml = mb; ms = ma; e = xb; sl = sb; ss = sa; d = xb - xa;
            end
            if (d > 25) d = 25;
            ms = ms >> d;
            r = (sl == ss) ? (ml + ms) : (ml - ms);
            n = 0;
            if (r == 0) begin
                o = 32'h0;
            end else begin
                while (r >= (1 << 24)) begin
                    r = r >> 1; e = e + 1; n = n + 1;
                end
                while (r < (1 << 23) && e > 1) begin
                    r = r << 1; e = e - 1; n = n + 1;
                end
                rv = r;
                if (e >= 255) o = {sl, 8'hFF, 23'd0};
                else o = {sl, (r >= (1 << 23)) ? 8'(e) : 8'd0, rv[22:0]};
            end
            lat = 3 + d + n;
        end
    endfunction

    // Present an operand pair and return just after the accepting edge
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        A = a;
        B = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded so a stuck design cannot hang the run
    task automatic wait_out(output int lat, output bit timed_out);
        lat = 0;
        timed_out = 1'b0;
        while (!out_valid) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat > 300) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    // Accept the pending result
    task automatic finish_op;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || O !== 32'h0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b O=%h busy=%b, want 1 0 00000000 0",
                     in_ready, out_valid, O, busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [31:0] da [10] = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h7F800000,
                                 32'h7FC00001, 32'h00000000, 32'h3F800000, 32'h4C000000, 32'h00000003};
        logic [31:0] db [10] = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h7F800000,
                                 32'h3F800000, 32'h40400000, 32'hFFC00000, 32'h3F800000, 32'h00000001};
        logic [31:0] dexp [10] = '{32'h40000000, 32'h00000000, 32'h40000000, 32'h34000000, 32'h7FC00000,
                                   32'h7FC00001, 32'hC0400000, 32'hFFC00000, 32'h4C000000, 32'h00000002};
        int dlat [10] = '{4, 3, 4, 26, 1, 1, 1, 1, 28, 3};
        int lat;
        bit to;
        for (int i = 0; i < 10; i++) begin
            start_op(da[i], db[i]);
            wait_out(lat, to);
            tests_run++;
            if (to || O !== dexp[i]) begin
                tests_failed++;
                $display("[TB] FAIL directed_%0d_value: O=%h timeout=%b, want %h", i, O, to, dexp[i]);
            end
            tests_run++;
            if (lat !== dlat[i]) begin
                tests_failed++;
                $display("[TB] FAIL directed_%0d_latency: got %0d edges, want %0d", i, lat, dlat[i]);
            end
            if (!to) finish_op;
        end
    endtask

    task automatic test_backpressure;
        int lat;
        bit to;
        start_op(32'h40400000, 32'h3F800000);
        wait_out(lat, to);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (out_valid !== 1'b1 || O !== 32'h40000000 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL backpressure_hold_%0d: out_valid=%b O=%h in_ready=%b, want 1 40000000 0",
                         i, out_valid, O, in_ready);
            end
        end
        finish_op;
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] exp_o;
        int exp_lat, lat;
        bit to;
        start_op(32'h4B000000, 32'h3F800000);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || O !== 32'h0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_align: in_ready=%b out_valid=%b O=%h busy=%b, want 1 0 00000000 0",
                     in_ready, out_valid, O, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_discard_%0d: out_valid=%b busy=%b, want 0 0", i, out_valid, busy);
            end
        end
        ref_model(32'h4B000000, 32'h3F800000, exp_o, exp_lat);
        start_op(32'h4B000000, 32'h3F800000);
        wait_out(lat, to);
        tests_run++;
        if (to || O !== exp_o || lat != exp_lat) begin
            tests_failed++;
            $display("[TB] FAIL after_reset_op: O=%h lat=%0d, want %h lat=%0d", O, lat, exp_o, exp_lat);
        end
        if (!to) finish_op;
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_o;
        int exp_lat, lat;
        bit to;
        start_op(32'h40400000, 32'h3F800000);
        wait_out(lat, to);
        ref_model(32'h41200000, 32'h40A00000, exp_o, exp_lat);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        A = 32'h41200000;
        B = 32'h40A00000;
        @(posedge clk);
        #1 out_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL no_overlap: in_ready=%b busy=%b out_valid=%b, want 1 0 0", in_ready, busy, out_valid);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out(lat, to);
        tests_run++;
        if (to || O !== exp_o || lat != exp_lat) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back_op: O=%h lat=%0d, want %h lat=%0d", O, lat, exp_o, exp_lat);
        end
        if (!to) finish_op;
    endtask

    task automatic test_random;
        logic [31:0] a, b, exp_o;
        int exp_lat, lat, ea, eb;
        bit to;
        for (int i = 0; i < 60; i++) begin
            ea = $urandom_range(0, 253);
            if ($urandom_range(0, 1) == 1) eb = ea + $urandom_range(0, 4) - 2;
            else eb = $urandom_range(0, 253);
            if (eb < 0) eb = 0;
            if (eb > 253) eb = 253;
            a = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
            b = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
            if (i % 7 == 3) b[22:0] = a[22:0];
            ref_model(a, b, exp_o, exp_lat);
            start_op(a, b);
            wait_out(lat, to);
            tests_run++;
            if (to || O !== exp_o) begin
                tests_failed++;
                $display("[TB] FAIL random_%0d_value: A=%h B=%h O=%h, want %h", i, a, b, O, exp_o);
            end
            tests_run++;
            if (lat != exp_lat) begin
                tests_failed++;
                $display("[TB] FAIL random_%0d_latency: A=%h B=%h got %0d, want %0d", i, a, b, lat, exp_lat);
            end
            if (!to) finish_op;
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        tests_run = 0;
        tests_failed = 0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = 32'h0;
        B = 32'h0;
        test_reset;
        test_directed;
        test_backpressure;
        test_reset_mid_op;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
